// File: rtl/text_console_writer.sv
// Character console writer: places characters into a cell buffer, handles CR/LF/BS,
// scrolls and clears. Optional macro TEXT_CONSOLE_BLANK_WRITE_EN restricts writes to blanking.
module text_console_writer #(
  parameter int          CharacterColumns = 60,
  parameter int          CharacterLines   = 33,
  parameter logic [7:0]  DefaultAttribute = 8'h0F,
  parameter int          AddressWidth     = $clog2(CharacterColumns*CharacterLines)
) (
  input  logic                                ScanClock,
  input  logic                                Reset,
  input  logic                                CharValid,
  input  logic [7:0]                          CharData,
  input  logic [7:0]                          CharAttribute,
  output logic                                CharReady,
  input  logic                                ClearRequest,
  input  logic                                Blanking,
  output logic [AddressWidth-1:0]             BufReadAddress,
  input  logic [15:0]                         BufReadData,
  output logic [AddressWidth-1:0]             BufWriteAddress,
  output logic [15:0]                         BufWriteData,
  output logic                                BufWriteEnable,
  output logic [$clog2(CharacterColumns)-1:0] CursorColumn,
  output logic [$clog2(CharacterLines)-1:0]   CursorLine,
  output logic                                Busy
);

  localparam int Cells = CharacterColumns * CharacterLines;
  localparam int CW    = $clog2(CharacterColumns);
  localparam int LW    = $clog2(CharacterLines);

  localparam logic [AddressWidth-1:0] ColsA     = AddressWidth'(CharacterColumns);
  localparam logic [AddressWidth-1:0] LastA     = AddressWidth'(Cells - 1);
  localparam logic [AddressWidth-1:0] LastLineA = AddressWidth'(Cells - CharacterColumns);
  localparam logic [CW-1:0]           LastCol   = CW'(CharacterColumns - 1);
  localparam logic [LW-1:0]           LastLine  = LW'(CharacterLines - 1);
  localparam logic [15:0]             BlankCell = {DefaultAttribute, 8'h20};

  typedef enum logic [2:0] {IDLE, WRITE, SCROLL_RD, SCROLL_WR, FILL} state_t;

  state_t                  state_q;
  logic [CW-1:0]           col_q;
  logic [LW-1:0]           line_q;
  logic                    we_q;
  logic                    clear_q;
  logic [AddressWidth-1:0] wa_q, ra_q;
  logic [15:0]             wd_q;
  logic [AddressWidth-1:0] cell_d;
  logic                    go;

`ifdef TEXT_CONSOLE_BLANK_WRITE_EN
  assign go = Blanking;
`else
  logic unused_blanking;
  assign unused_blanking = Blanking;
  assign go              = 1'b1;
`endif

  assign cell_d = AddressWidth'(line_q) * ColsA + AddressWidth'(col_q);

  always_ff @(posedge ScanClock) begin
    if (Reset) begin
      state_q <= FILL;
      col_q   <= '0;
      line_q  <= '0;
      we_q    <= 1'b0;
      clear_q <= 1'b1;
      wa_q    <= '0;
      ra_q    <= '0;
      wd_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ClearRequest) begin
            state_q <= FILL;
            we_q    <= 1'b1;
            wa_q    <= '0;
            wd_q    <= BlankCell;
            clear_q <= 1'b1;
          end else if (CharValid) begin
            case (CharData)
              8'h0D: col_q <= '0;
              8'h0A: begin
                col_q <= '0;
                if (line_q == LastLine) begin
                  state_q <= SCROLL_RD;
                  ra_q    <= ColsA;
                end else begin
                  line_q <= line_q + 1'b1;
                end
              end
              8'h08: if (col_q != '0) col_q <= col_q - 1'b1;
              default: begin
                state_q <= WRITE;
                we_q    <= 1'b1;
                wa_q    <= cell_d;
                wd_q    <= {CharAttribute, CharData};
              end
            endcase
          end
        end
        WRITE: begin
          if (go) begin
            we_q <= 1'b0;
            if (col_q == LastCol) begin
              col_q <= '0;
              if (line_q == LastLine) begin
                state_q <= SCROLL_RD;
                ra_q    <= ColsA;
              end else begin
                line_q  <= line_q + 1'b1;
                state_q <= IDLE;
              end
            end else begin
              col_q   <= col_q + 1'b1;
              state_q <= IDLE;
            end
          end
        end
        SCROLL_RD: begin
          state_q <= SCROLL_WR;
          we_q    <= 1'b1;
          wa_q    <= ra_q - ColsA;
        end
        // Read address is held while stalled, so the buffer keeps re-reading cell ra_q.
        SCROLL_WR: begin
          if (go) begin
            if (ra_q == LastA) begin
              state_q <= FILL;
              wa_q    <= LastLineA;
              wd_q    <= BlankCell;
              clear_q <= 1'b0;
            end else begin
              we_q    <= 1'b0;
              ra_q    <= ra_q + 1'b1;
              state_q <= SCROLL_RD;
            end
          end
        end
        FILL: begin
          if (!we_q) begin
            we_q <= 1'b1;
            wd_q <= BlankCell;
          end else if (go) begin
            if (wa_q == LastA) begin
              we_q    <= 1'b0;
              state_q <= IDLE;
              if (clear_q) begin
                col_q  <= '0;
                line_q <= '0;
              end
            end else begin
              wa_q <= wa_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign CharReady       = (state_q == IDLE) && !ClearRequest;
  assign Busy            = (state_q != IDLE);
  assign BufWriteEnable  = we_q && go;
  assign BufWriteAddress = wa_q;
  assign BufReadAddress  = ra_q;
  assign BufWriteData    = (state_q == SCROLL_WR) ? BufReadData : wd_q;
  assign CursorColumn    = col_q;
  assign CursorLine      = line_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: expected buffer writes are queued by the
// stimulus and popped by a monitor on every observed write.
module tb_text_console_writer;
  localparam int C  = 60;
  localparam int L  = 33;
  localparam int N  = C * L;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cv = 1'b0, clr = 1'b0, blank = 1'b1;
  logic [7:0]    cd = '0, ca = '0;
  logic          ready, we, busy;
  logic [AW-1:0] ra, wa;
  logic [15:0]   wd, rdata;
  logic [5:0]    ccol, cline;

  always #5 clk = ~clk;

  text_console_writer dut (
    .ScanClock(clk), .Reset(rst), .CharValid(cv), .CharData(cd), .CharAttribute(ca),
    .CharReady(ready), .ClearRequest(clr), .Blanking(blank),
    .BufReadAddress(ra), .BufReadData(rdata), .BufWriteAddress(wa), .BufWriteData(wd),
    .BufWriteEnable(we), .CursorColumn(ccol), .CursorLine(cline), .Busy(busy)
  );

  // Synchronous buffer RAM with one-cycle read latency
  logic [15:0] mem [N];
  always @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rdata <= mem[ra];
  end

  typedef struct packed { logic [AW-1:0] a; logic [15:0] d; } wr_t;
  wr_t         expq[$];
  logic [15:0] refm [N];
  int          checks = 0, errors = 0;
  int          mcol = 0, mline = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && we) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected none", wa, wd);
      end else begin
        wr_t e;
        e = expq.pop_front();
        chk("write_addr", 32'(wa), 32'(e.a));
        chk("write_data", 32'(wd), 32'(e.d));
      end
    end
  end

  task automatic push_write(input int a, input logic [15:0] d);
    wr_t e;
    e.a = AW'(a);
    e.d = d;
    expq.push_back(e);
    refm[a] = d;
  endtask

  task automatic push_fill(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) push_write(i, 16'h0F20);
  endtask

  task automatic push_scroll();
    for (int k = 0; k < N - C; k++) push_write(k, refm[k + C]);
    push_fill(N - C, N - 1);
  endtask

  task automatic settle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, 32'(busy), 32'd0);
    chk({name, "_col"}, 32'(ccol), 32'(mcol));
    chk({name, "_line"}, 32'(cline), 32'(mline));
    chk({name, "_queue_left"}, 32'(expq.size()), 32'd0);
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] attr, input bit lat_chk);
    int t;
    @(negedge clk);
    cv = 1'b1; cd = c; ca = attr;
    t = 0;
    while (!ready && t < 10000) begin
      @(negedge clk);
      t++;
    end
    chk("ready_timeout", 32'(ready), 32'd1);
    if (c == 8'h0D) mcol = 0;
    else if (c == 8'h0A) begin
      mcol = 0;
      if (mline == L - 1) push_scroll(); else mline++;
    end else if (c == 8'h08) begin
      if (mcol != 0) mcol--;
    end else begin
      push_write(mline * C + mcol, {attr, c});
      if (mcol == C - 1) begin
        mcol = 0;
        if (mline == L - 1) push_scroll(); else mline++;
      end else mcol++;
    end
    @(posedge clk);
    #1 cv = 1'b0;
    if (lat_chk && c != 8'h0D && c != 8'h0A && c != 8'h08) begin
      @(negedge clk);
      chk("write_latency", 32'(we), 32'd1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    expq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    mcol = 0; mline = 0;
    push_fill(0, N - 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_waddr", 32'(wa), 32'd0);
    chk("rst_raddr", 32'(ra), 32'd0);
    chk("rst_wdata", 32'(wd), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_cursor", 32'({ccol, cline}), 32'd0);
    rst = 1'b0;
    push_fill(0, N - 1);
    settle("init_clear");
    chk("ready_after_clear", 32'(ready), 32'd1);

    send(8'h41, 8'h1E, 1'b1);
    settle("char_A");
    chk("A_cell", 32'(mem[0]), 32'h1E41);

    send(8'h0D, 8'h00, 1'b0);
    settle("cr");
    for (int i = 0; i < 5; i++) send(8'h0A, 8'h00, 1'b0);
    settle("lf5");
    for (int i = 0; i < 59; i++) send(8'h78, 8'h07, 1'b1);
    settle("to_col59");
    chk("col59", 32'(ccol), 32'd59);
    send(8'h42, 8'h2A, 1'b1);
    settle("wrap_B");
    chk("B_cell", 32'(mem[359]), 32'h2A42);
    chk("wrap_col", 32'(ccol), 32'd0);
    chk("wrap_line", 32'(cline), 32'd6);

    send(8'h08, 8'h00, 1'b0);
    settle("bs_at_0");
    send(8'h43, 8'h31, 1'b1);
    send(8'h08, 8'h00, 1'b0);
    settle("bs_after_C");

    while (mline < L - 1) send(8'h0A, 8'h00, 1'b0);
    settle("to_last_line");
    chk("last_line", 32'(cline), 32'd32);

    // Scroll, with a clear request during it that must be ignored
    send(8'h0A, 8'h00, 1'b0);
    repeat (50) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    settle("scroll");
    chk("scroll_B_moved", 32'(mem[299]), 32'h2A42);

    // Clear and character in the same idle cycle: clear wins
    @(negedge clk);
    clr = 1'b1; cv = 1'b1; cd = 8'h5A; ca = 8'h44;
    #1 chk("ready_under_clear", 32'(ready), 32'd0);
    mcol = 0; mline = 0;
    push_fill(0, N - 1);
    @(posedge clk);
    #1 clr = 1'b0; cv = 1'b0;
    settle("clear_vs_char");

    // Reset in the middle of a clear restarts from address 0
    send(8'h41, 8'h1E, 1'b1);
    settle("pre_mid_reset");
    @(negedge clk);
    clr = 1'b1;
    mcol = 0; mline = 0;
    push_fill(0, N - 1);
    @(posedge clk);
    #1 clr = 1'b0;
    repeat (300) @(negedge clk);
    do_reset();
    settle("mid_reset");

`ifdef TEXT_CONSOLE_BLANK_WRITE_EN
    @(negedge clk);
    blank = 1'b0;
    send(8'h51, 8'h5A, 1'b0);
    repeat (10) begin
      @(negedge clk);
      chk("stall_we", 32'(we), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    blank = 1'b1;
    settle("blank_release");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/text_console_writer.md
TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 Parameter CharacterColumns, default 60: text columns per line.
REQ-002 Parameter CharacterLines, default 33: text lines per screen.
REQ-003 Parameter DefaultAttribute, default 8'h0F: blank-cell attribute, {BgC[3:0], FgC[3:0]}.
REQ-004 Parameter AddressWidth, default $clog2(CharacterColumns*CharacterLines): buffer address width.
REQ-005 ScanClock  in  1  sole clock; every register updates on its rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 CharValid  in  1  character offered.
REQ-008 CharData  in  8  character code.
REQ-009 CharAttribute  in  8  {BgC, FgC}, sampled with CharData.
REQ-010 CharReady  out  1  character accepted when CharValid && CharReady.
REQ-011 ClearRequest  in  1  single-cycle clear-screen request.
REQ-012 Blanking  in  1  display blanking indicator (LineBlanking | FrameBlanking).
REQ-013 BufReadAddress  out  AddressWidth  cell read address.
REQ-014 BufReadData  in  16  cell word; valid exactly one cycle after BufReadAddress.
REQ-015 BufWriteAddress  out  AddressWidth  cell write address.
REQ-016 BufWriteData  out  16  {BgC, FgC, Char}.
REQ-017 BufWriteEnable  out  1  one cell write per asserted cycle.
REQ-018 CursorColumn / CursorLine  out  $clog2 widths  current cursor position.
REQ-019 Busy  out  1  high in every state except IDLE.

Function
REQ-020 States: IDLE, WRITE, SCROLL_RD, SCROLL_WR, FILL.
REQ-021 CharReady = 1 only in IDLE with ClearRequest low; ClearRequest has priority over CharValid in the same cycle.
REQ-022 A printable code (not 0x08/0x0A/0x0D) accepted in cycle N produces BufWriteEnable in cycle N+1 at address CursorLine*CharacterColumns+CursorColumn, data {CharAttribute, CharData}, then the cursor advances.
REQ-023 Column advance past CharacterColumns-1 wraps to column 0 and the next line.
REQ-024 0x0D: column set to 0; no write; stays in IDLE.
REQ-025 0x0A: column set to 0, line incremented; no write.
REQ-026 0x08: column decremented if nonzero, otherwise unchanged; no write.
REQ-027 A line increment from CharacterLines-1 does not wrap: the line stays at CharacterLines-1 and a scroll starts.
REQ-028 Scroll: for i = CharacterColumns .. Cols*Lines-1, SCROLL_RD drives BufReadAddress=i, then SCROLL_WR writes BufReadData to i-CharacterColumns; 2 cycles per cell.
REQ-029 After the scroll, FILL writes {DefaultAttribute, 8'h20} to every cell of the last line, one per cycle, then returns to IDLE.
REQ-030 Clear: FILL over all Cols*Lines cells starting at 0, then cursor (0,0), then IDLE.
REQ-031 ClearRequest asserted outside IDLE is ignored.
REQ-032 Cell indices use AddressWidth-bit unsigned arithmetic; no address exceeds Cols*Lines-1.

Reset
REQ-033 On Reset: state FILL (full clear), cursor (0,0), BufWriteEnable 0, BufWriteAddress 0, BufReadAddress 0, BufWriteData 0, CharReady 0, Busy 1.
REQ-034 Reset asserted mid-scroll or mid-fill abandons the operation and restarts the full clear from address 0 on the following cycle.

Configuration
REQ-035 Macro TEXT_CONSOLE_BLANK_WRITE_EN defined: BufWriteEnable is asserted only while Blanking = 1; WRITE, SCROLL_WR and FILL hold state, address and data until Blanking = 1; SCROLL_RD re-reads after any stall.
REQ-036 Macro TEXT_CONSOLE_BLANK_WRITE_EN undefined: Blanking is ignored and writes proceed every eligible cycle.

Verification
REQ-037 Reset release -> 1980 consecutive writes, addresses 0..1979, data 16'h0F20; CharReady rises afterwards; cursor (0,0).
REQ-038 Send 'A' (8'h41, attribute 8'h1E) -> write at address 0 with data 16'h1E41, one cycle after acceptance; cursor (1,0).
REQ-039 Cursor at (59,5), send 'B' -> write at address 359; cursor (0,6).
REQ-040 Cursor at line 32, send 0x0A -> 1920 copies (address 60+k read, 60+k-60 written), then 60 fills at 1920..1979; cursor (0,32).
REQ-041 ClearRequest and CharValid high in the same IDLE cycle -> character not accepted; full clear executes; cursor (0,0).
REQ-042 With TEXT_CONSOLE_BLANK_WRITE_EN defined, Blanking held at 0 -> BufWriteEnable stays 0 and Busy stays 1; Blanking raised -> the pending write completes unchanged.
